// File: rtl/lfsr_stream_checker.sv
// Checks a Galois LFSR word stream: locks after LOCK_N correct transitions, then flags and counts mismatches.
// Optional sequence-period measurement is enabled by defining LFSR_CHK_PERIOD_EN.
module lfsr_stream_checker #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b0110,
    parameter int               LOCK_N   = 3,
    parameter int               UNLOCK_N = 4,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       period,
    output logic             period_valid
);

    typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [3:0]       LOCK_C   = 4'(LOCK_N);
    localparam logic [3:0]       UNLOCK_C = 4'(UNLOCK_N);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r[0] = x[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            r[i] = x[i-1] ^ (TAPS[i] & x[WIDTH-1]);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             good_s;
    logic             err_s;
    logic [3:0]       match_inc_s;
    logic [3:0]       miss_inc_s;

    assign good_s      = (in_data == nxt(prev_q)) && (in_data != {WIDTH{1'b0}});
    assign err_s       = in_valid && (state_q == LOCKED) && !good_s;
    assign match_inc_s = match_cnt_q + 4'd1;
    assign miss_inc_s  = miss_cnt_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            prev_q      <= {WIDTH{1'b0}};
            prev_ok_q   <= 1'b0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (prev_ok_q && good_s && (match_inc_s == LOCK_C)) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!good_s && (miss_inc_s == UNLOCK_C)) begin
                        state_d = SEARCH;
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_comb begin
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = (state_d == LOCKED);
        err_pulse_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (!prev_ok_q) begin
                        prev_d    = in_data;
                        prev_ok_d = 1'b1;
                    end else if (good_s) begin
                        prev_d      = in_data;
                        match_cnt_d = (match_inc_s == LOCK_C) ? 4'd0 : match_inc_s;
                        if (match_inc_s == LOCK_C) begin
                            miss_cnt_d = 4'd0;
                        end else begin
                            miss_cnt_d = miss_cnt_q;
                        end
                    end else begin
                        prev_d      = in_data;
                        match_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (good_s) begin
                        prev_d     = in_data;
                        miss_cnt_d = 4'd0;
                    end else if (miss_inc_s == UNLOCK_C) begin
                        err_pulse_d = 1'b1;
                        prev_d      = in_data;
                        match_cnt_d = 4'd0;
                        miss_cnt_d  = 4'd0;
                    end else begin
                        // Flywheel: keep the predicted sequence so one bad word does not lose sync
                        err_pulse_d = 1'b1;
                        prev_d      = nxt(prev_q);
                        miss_cnt_d  = miss_inc_s;
                    end
                end
                default: begin
                    prev_d = prev_q;
                end
            endcase
        end else begin
            prev_d = prev_q;
        end
    end

    // A clear coinciding with an error leaves a count of one so that error is kept
    always_comb begin
        err_count_d = err_count_q;
        if (clr_cnt) begin
            err_count_d = err_s ? CNT_ONE : {CNT_W{1'b0}};
        end else if (err_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef LFSR_CHK_PERIOD_EN
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             ref_ok_q, ref_ok_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [7:0]       period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [7:0]       pcnt_inc_s;

    assign pcnt_inc_s = (pcnt_q == 8'hFF) ? 8'hFF : (pcnt_q + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q          <= {WIDTH{1'b0}};
            ref_ok_q       <= 1'b0;
            pcnt_q         <= 8'd0;
            period_q       <= 8'd0;
            period_valid_q <= 1'b0;
        end else begin
            ref_q          <= ref_d;
            ref_ok_q       <= ref_ok_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    always_comb begin
        ref_d          = ref_q;
        ref_ok_d       = ref_ok_q;
        pcnt_d         = pcnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (in_valid && (state_q == SEARCH) && (state_d == LOCKED)) begin
            ref_d    = in_data;
            ref_ok_d = 1'b1;
            pcnt_d   = 8'd0;
        end else if (in_valid && (state_q == LOCKED) && (state_d == SEARCH)) begin
            ref_ok_d = 1'b0;
        end else if (in_valid && (state_q == LOCKED) && good_s) begin
            if (ref_ok_q && (in_data == ref_q)) begin
                period_d       = pcnt_inc_s;
                period_valid_d = 1'b1;
                pcnt_d         = 8'd0;
            end else begin
                pcnt_d = pcnt_inc_s;
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`else
    assign period       = 8'd0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: directed vectors push expected outputs, a monitor pops and compares.
module tb_lfsr_stream_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       clr_cnt = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] period;
    logic       period_valid;

    typedef struct packed {
        logic       l;
        logic       p;
        logic [7:0] c;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       acc_q = 1'b0;
    logic       per_win = 1'b0;
    int         strobes = 0;
    int         idx = 0;
    logic [3:0] seq [7] = '{4'b1111, 4'b1001, 4'b0101, 4'b1010, 4'b0011, 4'b0110, 4'b1100};

    lfsr_stream_checker #(
        .WIDTH(4), .TAPS(4'b0110), .LOCK_N(3), .UNLOCK_N(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .period(period), .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic clr, input logic el, input logic ep,
                        input logic [7:0] ec);
        exp_t e;
        e.l = el; e.p = ep; e.c = ec;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        clr_cnt  = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 4'b0000;
        clr_cnt  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic send_good(input logic clr, input logic el, input logic [7:0] ec);
        send(seq[idx], clr, el, 1'b0, ec);
        idx = (idx + 1) % 7;
    endtask

    always @(posedge clk) acc_q <= in_valid & ~rst;

    // Pops one expectation per accepted sample; between samples err_pulse must stay low
    always @(negedge clk) begin
        exp_t e;
        if (acc_q) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("locked", int'(locked), int'(e.l));
                chk("err_pulse", int'(err_pulse), int'(e.p));
                chk("err_count", int'(err_count), int'(e.c));
`ifndef LFSR_CHK_PERIOD_EN
                chk("period_off", int'(period), 0);
                chk("period_valid_off", int'(period_valid), 0);
`endif
            end
        end else begin
            chk("idle_err_pulse", int'(err_pulse), 0);
        end
`ifdef LFSR_CHK_PERIOD_EN
        if (period_valid && per_win) begin
            chk("period", int'(period), 7);
            strobes++;
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        #2;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_period_valid", int'(period_valid), 0);
        idle(); idle();
        rst = 1'b0;
        idle();

        // Initial lock: locked rises on the sample of 1010
        send(4'b1111, 1'b0, 1'b0, 1'b0, 8'd0);
        send(4'b1001, 1'b0, 1'b0, 1'b0, 8'd0);
        send(4'b0101, 1'b0, 1'b0, 1'b0, 8'd0);
        send(4'b1010, 1'b0, 1'b1, 1'b0, 8'd0);

        // Single corrupted word is absorbed by the flywheel
        send(4'b0011, 1'b0, 1'b1, 1'b0, 8'd0);
        send(4'b0000, 1'b0, 1'b1, 1'b1, 8'd1);
        send(4'b1100, 1'b0, 1'b1, 1'b0, 8'd1);

        // Four consecutive wrong words drop lock on the fourth
        send(4'b0001, 1'b0, 1'b1, 1'b1, 8'd2);
        send(4'b0001, 1'b0, 1'b1, 1'b1, 8'd3);
        send(4'b0001, 1'b0, 1'b1, 1'b1, 8'd4);
        send(4'b0001, 1'b0, 1'b0, 1'b1, 8'd5);

        // Relock after LOCK_N+1 correct words
        send(4'b0011, 1'b0, 1'b0, 1'b0, 8'd5);
        send(4'b0110, 1'b0, 1'b0, 1'b0, 8'd5);
        send(4'b1100, 1'b0, 1'b0, 1'b0, 8'd5);
        send(4'b1111, 1'b0, 1'b1, 1'b0, 8'd5);
        send(4'b1001, 1'b0, 1'b1, 1'b0, 8'd5);
        send(4'b0101, 1'b0, 1'b1, 1'b0, 8'd5);
        send(4'b1010, 1'b0, 1'b1, 1'b0, 8'd5);
        send(4'b0011, 1'b1, 1'b1, 1'b0, 8'd0);
        idx = 5;

        // Two full clean cycles
        per_win = 1'b1;
        for (int k = 0; k < 14; k++) send_good(1'b0, 1'b1, 8'd0);
        idle();
        per_win = 1'b0;
`ifdef LFSR_CHK_PERIOD_EN
        chk("period_strobes", strobes, 2);
`endif

        // Asynchronous reset mid-lock
        idle();
        chk("pre_rst_locked", int'(locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_count", int'(err_count), 0);
        idle();
        rst = 1'b0;
        idle();

        // Gapped stream: lock counted in valid samples only
        idx = 0;
        send_good(1'b0, 1'b0, 8'd0); idle();
        send_good(1'b0, 1'b0, 8'd0); idle();
        send_good(1'b0, 1'b0, 8'd0); idle();
        send_good(1'b0, 1'b1, 8'd0); idle();

        // Saturation: groups of three errors then one good word keep lock
        c = 8'd0;
        for (int g = 0; g < 86; g++) begin
            for (int b = 0; b < 3; b++) begin
                c = (c == 8'd255) ? 8'd255 : c + 8'd1;
                send(4'b0000, 1'b0, 1'b1, 1'b1, c);
                idx = (idx + 1) % 7;
            end
            send_good(1'b0, 1'b1, c);
        end

        // Clear coincident with an error, then a plain clear
        send(4'b0000, 1'b1, 1'b1, 1'b1, 8'd1);
        idx = (idx + 1) % 7;
        send_good(1'b1, 1'b1, 8'd0);

        idle(); idle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
